acc_uart_logger: RTL and testbench

Downstream consumer of the simple CPU's accumulator debug output. Watches `debug_output_acc` every clock, queues each new value in a small FIFO, and streams it out of a UART TX pin as ASCII hex records. Lets the board report ACC activity to a host terminal without a logic analyser. Sits beside `simple_cpu` at board top level on the same 50 MHz clock and KEY0 reset.

---
 rtl/acc_uart_logger.sv | 230 +++++++++++++++++++++++
 tb/tb_acc_uart_logger.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_uart_logger.sv
// Accumulator activity logger: queues each change of acc_in and sends it as an ASCII hex record over UART 8N1.
// Build option: define ACC_LOG_CRLF_EN for "HL\r\n" records; otherwise records are "HL " (hex, hex, space).
module acc_uart_logger #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk_50mhz,
   input  logic                          key0_n,
   input  logic [7:0]                    acc_in,
   output logic                          uart_tx,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
   localparam logic [LW-1:0] LEVEL_MAX = LW'(FIFO_DEPTH);
`ifdef ACC_LOG_CRLF_EN
   localparam logic [1:0] LAST_CHAR = 2'd3;
`else
   localparam logic [1:0] LAST_CHAR = 2'd2;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t          state_reg, state_next;
   logic [7:0]      prev_reg;
   logic [7:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [LW-1:0]   level_reg;
   logic            overflow_reg;
   logic [7:0]      record_reg;
   logic [1:0]      char_idx_reg, char_idx_next;
   logic [7:0]      shift_reg, shift_next;
   logic [2:0]      bit_cnt_reg, bit_cnt_next;
   logic [BW-1:0]   baud_reg, baud_next;

   logic            change;
   logic            fifo_empty;
   logic            fifo_full;
   logic            push;
   logic            pop;
   logic            drop;
   logic [7:0]      hex_char [2];
   logic [7:0]      cur_char;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   endfunction

   // ------------------------------------------------------------------
   // Change detect and FIFO bookkeeping
   // ------------------------------------------------------------------
   assign change     = (acc_in != prev_reg);
   assign fifo_empty = (level_reg == '0);
   assign fifo_full  = (level_reg == LEVEL_MAX);
   assign pop        = (state_reg == S_IDLE) && !fifo_empty;
   // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
   assign push       = change && (!fifo_full || pop);
   assign drop       = change && fifo_full && !pop;

   always_ff @(posedge clk_50mhz or negedge key0_n) begin
      if (!key0_n) begin
         prev_reg     <= 8'h00;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (change) begin
            prev_reg <= acc_in;
         end
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + LW'(1);
            2'b01:   level_reg <= level_reg - LW'(1);
            default: level_reg <= level_reg;
         endcase
         if (drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // Storage and record register carry no reset so the array maps onto RAM.
   always_ff @(posedge clk_50mhz) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= acc_in;
      end
      if (pop) begin
         record_reg <= fifo_mem[rd_ptr_reg];
      end
   end

   // ------------------------------------------------------------------
   // Character selection
   // ------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_hex
         assign hex_char[gi] = hex_ascii(record_reg[gi*4 +: 4]);
      end
   endgenerate

   always_comb begin
      cur_char = 8'h20;
      case (char_idx_reg)
         2'd0: cur_char = hex_char[1];
         2'd1: cur_char = hex_char[0];
`ifdef ACC_LOG_CRLF_EN
         2'd2: cur_char = 8'h0D;
         2'd3: cur_char = 8'h0A;
`else
         2'd2: cur_char = 8'h20;
         2'd3: cur_char = 8'h20;
`endif
         default: cur_char = 8'h20;
      endcase
   end

   // ------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_50mhz or negedge key0_n) begin
      if (!key0_n) begin
         state_reg    <= S_IDLE;
         char_idx_reg <= 2'd0;
         shift_reg    <= 8'h00;
         bit_cnt_reg  <= 3'd0;
         baud_reg     <= BAUD_MAX;
      end else begin
         state_reg    <= state_next;
         char_idx_reg <= char_idx_next;
         shift_reg    <= shift_next;
         bit_cnt_reg  <= bit_cnt_next;
         baud_reg     <= baud_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      char_idx_next = char_idx_reg;
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      baud_next     = baud_reg;

      case (state_reg)
         S_IDLE: begin
            if (pop) begin
               state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            shift_next = cur_char;
            state_next = S_START;
         end
         S_START: begin
            if (baud_reg == '0) begin
               bit_cnt_next = 3'd0;
               state_next   = S_DATA;
            end else begin
               baud_next = baud_reg - BW'(1);
            end
         end
         S_DATA: begin
            if (baud_reg == '0) begin
               baud_next = BAUD_MAX;
               if (bit_cnt_reg == 3'd7) begin
                  state_next = S_STOP;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 3'd1;
                  shift_next   = {1'b0, shift_reg[7:1]};
               end
            end else begin
               baud_next = baud_reg - BW'(1);
            end
         end
         S_STOP: begin
            if (baud_reg == '0) begin
               if (char_idx_reg < LAST_CHAR) begin
                  char_idx_next = char_idx_reg + 2'd1;
                  state_next    = S_LOAD;
               end else begin
                  char_idx_next = 2'd0;
                  state_next    = S_IDLE;
               end
            end else begin
               baud_next = baud_reg - BW'(1);
            end
         end
         default: begin
            state_next    = S_IDLE;
            char_idx_next = 2'd0;
         end
      endcase

      // Every state is timed from a freshly loaded baud counter.
      if (state_next != state_reg) begin
         baud_next = BAUD_MAX;
      end
   end

   // Decoded from registered state, so reset drives the line high without waiting for a clock.
   always_comb begin
      uart_tx = 1'b1;
      case (state_reg)
         S_START: uart_tx = 1'b0;
         S_DATA:  uart_tx = shift_reg[0];
         default: uart_tx = 1'b1;
      endcase
   end

   assign busy       = (state_reg != S_IDLE) || !fifo_empty;
   assign overflow   = overflow_reg;
   assign fifo_level = level_reg;

endmodule

// File: tb/tb_acc_uart_logger.sv
// Self-checking bench for acc_uart_logger: a UART receiver decodes uart_tx and compares against a byte scoreboard.
module tb_acc_uart_logger;

   localparam int CPB        = 4;
   localparam int DEPTH      = 4;
   localparam int LW         = $clog2(DEPTH) + 1;
   localparam int CHAR_CLKS  = 10 * CPB + 1;
   localparam int RX_TIMEOUT = 400;
`ifdef ACC_LOG_CRLF_EN
   localparam int         NCH = 4;
   localparam logic [7:0] CH2 = 8'h0D;
`else
   localparam int         NCH = 3;
   localparam logic [7:0] CH2 = 8'h20;
`endif

   logic          clk_50mhz = 1'b0;
   logic          key0_n    = 1'b0;
   logic [7:0]    acc_in    = 8'h00;
   logic          uart_tx;
   logic          busy;
   logic          overflow;
   logic [LW-1:0] fifo_level;

   int          cyc    = 0;
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  exp_q[$];
   string       hex_digits = "0123456789ABCDEF";

   acc_uart_logger #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_50mhz (clk_50mhz),
      .key0_n    (key0_n),
      .acc_in    (acc_in),
      .uart_tx   (uart_tx),
      .busy      (busy),
      .overflow  (overflow),
      .fifo_level(fifo_level)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   always @(posedge clk_50mhz) cyc <= cyc + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_record(input logic [7:0] v);
      exp_q.push_back(8'(hex_digits[v[7:4]]));
      exp_q.push_back(8'(hex_digits[v[3:0]]));
      exp_q.push_back(CH2);
      if (NCH == 4) exp_q.push_back(8'h0A);
   endtask

   // Receives one 8N1 character; every sample of every bit must agree, which pins bit widths to CPB clocks.
   task automatic rx_char(output logic [7:0] b, output int start_cyc, output bit ok);
      logic s [40];
      int   n;
      bit   frame_ok;
      logic ref_bit;
      ok        = 1'b0;
      b         = 8'h00;
      start_cyc = -1;
      for (n = 0; n < RX_TIMEOUT; n++) begin
         @(negedge clk_50mhz);
         if (uart_tx === 1'b0) break;
      end
      if (n == RX_TIMEOUT) begin
         checks++;
         errors++;
         $display("FAIL rx_timeout: no start bit within %0d clocks (uart_tx=%b)", RX_TIMEOUT, uart_tx);
         return;
      end
      start_cyc = cyc;
      s[0] = uart_tx;
      for (int k = 1; k < 40; k++) begin
         @(negedge clk_50mhz);
         s[k] = uart_tx;
      end
      frame_ok = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (k < CPB)            ref_bit = 1'b0;
         else if (k >= 9 * CPB)  ref_bit = 1'b1;
         else                    ref_bit = s[(k / CPB) * CPB];
         if (s[k] !== ref_bit) frame_ok = 1'b0;
      end
      for (int i = 0; i < 8; i++) b[i] = s[(i + 1) * CPB];
      checks++;
      if (!frame_ok) begin
         errors++;
         $display("FAIL frame_shape: char at cycle %0d has a bit not held %0d clocks or bad start/stop, got byte %02h", start_cyc, CPB, b);
      end
      ok = 1'b1;
   endtask

   task automatic rx_record(output int first_start, output int last_start);
      logic [7:0] b;
      logic [7:0] e;
      int         st;
      int         prev_st;
      bit         ok;
      first_start = -1;
      last_start  = -1;
      prev_st     = -1;
      for (int i = 0; i < NCH; i++) begin
         rx_char(b, st, ok);
         if (!ok) return;
         if (i == 0) first_start = st;
         last_start = st;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected: got byte %02h, required nothing", b);
         end else begin
            e = exp_q.pop_front();
            if (b !== e) begin
               errors++;
               $display("FAIL rx_byte[%0d]: got %02h, required %02h", i, b, e);
            end
         end
         if (i > 0) begin
            checks++;
            if (st - prev_st != CHAR_CLKS) begin
               errors++;
               $display("FAIL char_spacing: got %0d clocks, required %0d", st - prev_st, CHAR_CLKS);
            end
         end
         prev_st = st;
      end
      $display("rx record: %0d chars, first start at cycle %0d", NCH, first_start);
   endtask

   task automatic test_reset();
      bit bad;
      key0_n = 1'b0;
      acc_in = 8'h00;
      #100;
      checks++; if (uart_tx !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b, required 1", uart_tx); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
      checks++; if (fifo_level !== '0)  begin errors++; $display("FAIL reset_level: got %0d, required 0", fifo_level); end
      @(negedge clk_50mhz);
      key0_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk_50mhz);
         if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_level !== '0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL reset_idle: activity seen with acc_in=00 (tx=%b busy=%b level=%0d), required quiet", uart_tx, busy, fifo_level);
      end
      $display("reset idle: 500 clocks observed");
   endtask

   task automatic test_single_record();
      int n_edge, f, l, fall;
      @(negedge clk_50mhz);
      acc_in = 8'h3C;
      n_edge = cyc + 1;
      push_record(8'h3C);
      rx_record(f, l);
      checks++;
      if (f != n_edge + 2) begin
         errors++;
         $display("FAIL start_latency: tx fell after edge %0d, required edge %0d", f, n_edge + 2);
      end
      fall = -1;
      for (int i = 0; i < 200; i++) begin
         if (busy === 1'b0) begin fall = cyc; break; end
         @(negedge clk_50mhz);
      end
      checks++;
      if (fall != n_edge + 1 + NCH * CHAR_CLKS) begin
         errors++;
         $display("FAIL busy_fall: busy fell after edge %0d, required edge %0d", fall, n_edge + 1 + NCH * CHAR_CLKS);
      end
   endtask

   task automatic test_hex_letters();
      int  f, l;
      bit  extra;
      @(negedge clk_50mhz);
      acc_in = 8'hAF;
      push_record(8'hAF);
      rx_record(f, l);
      extra = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk_50mhz);
         if (uart_tx !== 1'b1) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL hex_no_extra: uart_tx left idle after a %0d-char record, required idle", NCH);
      end
   endtask

   task automatic test_back_to_back();
      fork
         begin
            for (int v = 1; v <= 6; v++) begin
               @(negedge clk_50mhz);
               acc_in = 8'(v);
               // Only one pop happens during the burst, so the sixth change finds the FIFO full.
               if (v <= 5) push_record(8'(v));
            end
            @(negedge clk_50mhz);
            checks++;
            if (fifo_level !== LW'(4)) begin
               errors++;
               $display("FAIL burst_level: got %0d, required 4", fifo_level);
            end
            checks++;
            if (overflow !== 1'b1) begin
               errors++;
               $display("FAIL burst_overflow: got %b, required 1", overflow);
            end
         end
         begin
            int f, l, prev_l;
            prev_l = -1;
            for (int r = 0; r < 5; r++) begin
               rx_record(f, l);
               if (r > 0) begin
                  checks++;
                  if (f - prev_l != CHAR_CLKS + 1) begin
                     errors++;
                     $display("FAIL record_gap: got %0d clocks between starts, required %0d", f - prev_l, CHAR_CLKS + 1);
                  end
               end
               prev_l = l;
            end
         end
      join
      repeat (10) @(negedge clk_50mhz);
      checks++;
      if (overflow !== 1'b1 || fifo_level !== '0 || busy !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL burst_after: overflow=%b level=%0d busy=%b pending=%0d, required 1/0/0/0", overflow, fifo_level, busy, exp_q.size());
      end
   endtask

   task automatic test_repeat_suppression();
      int  f, l;
      bit  extra;
      @(negedge clk_50mhz);
      acc_in = 8'h12;
      push_record(8'h12);
      rx_record(f, l);
      extra = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_50mhz);
         if (i == 800) acc_in = 8'h12;
         if (uart_tx !== 1'b1 || fifo_level !== '0) extra = 1'b1;
      end
      checks++;
      if (extra) begin
         errors++;
         $display("FAIL repeat_suppress: activity while 12 held (tx=%b level=%0d), required one record only", uart_tx, fifo_level);
      end
   endtask

   task automatic test_mid_frame_reset();
      logic [7:0] b;
      logic [7:0] e;
      int         st, n;
      bit         ok, bad;
      @(negedge clk_50mhz); acc_in = 8'h21;
      push_record(8'h21);
      @(negedge clk_50mhz); acc_in = 8'h22;
      @(negedge clk_50mhz); acc_in = 8'h23;
      rx_char(b, st, ok);
      if (ok) begin
         e = exp_q.pop_front();
         checks++;
         if (b !== e) begin
            errors++;
            $display("FAIL midreset_first_char: got %02h, required %02h", b, e);
         end
      end
      for (n = 0; n < RX_TIMEOUT; n++) begin
         @(negedge clk_50mhz);
         if (uart_tx === 1'b0) break;
      end
      checks++;
      if (n == RX_TIMEOUT) begin
         errors++;
         $display("FAIL midreset_second_start: no start bit within %0d clocks", RX_TIMEOUT);
      end
      repeat (CPB + 2) @(negedge clk_50mhz);
      checks++;
      if (overflow !== 1'b1 || fifo_level !== LW'(2)) begin
         errors++;
         $display("FAIL midreset_pre: overflow=%b level=%0d, required 1 and 2", overflow, fifo_level);
      end
      #5;
      key0_n = 1'b0;
      #1;
      checks++; if (uart_tx !== 1'b1)  begin errors++; $display("FAIL midreset_tx: got %b, required 1", uart_tx); end
      checks++; if (fifo_level !== '0) begin errors++; $display("FAIL midreset_level: got %0d, required 0", fifo_level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow: got %b, required 0", overflow); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midreset_busy: got %b, required 0", busy); end
      exp_q.delete();
      acc_in = 8'h00;
      repeat (3) @(negedge clk_50mhz);
      key0_n = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_50mhz);
         if (uart_tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL midreset_residual: activity after release (tx=%b busy=%b), required idle", uart_tx, busy);
      end
      $display("mid-frame reset: released at cycle %0d", cyc);
   endtask

   initial begin
      test_reset();
      test_single_record();
      test_hex_letters();
      test_back_to_back();
      test_repeat_suppression();
      test_mid_frame_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
